alu_result_stage: RTL and testbench

- Registered stage directly downstream of the 16-bit ripple-carry adder/subtractor.
- Captures each sum/difference with its carry/borrow and overflow, and derives N and Z flags.
- Holds the result in an accumulator that is fed back as the adder's A operand, and keeps a status register with sticky overflow.
- Buffers results in a small FIFO behind a valid/ready handshake toward the writeback consumer.

---
 rtl/alu_pkg.sv | 16 +
 rtl/result_fifo.sv | 72 +++++++
 rtl/alu_result_stage.sv | 111 +++++++++++
 tb/tb_alu_result_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage.
// Holds the default datapath width, the flag bit positions used in the
// {N,Z,C,V} flag nibble and the {SV,N,Z,C,V} status word, and the flag type.
package alu_pkg;

  localparam int unsigned WIDTH = 16;

  localparam int unsigned FLAG_V  = 0;
  localparam int unsigned FLAG_C  = 1;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_N  = 3;
  localparam int unsigned STAT_SV = 4;

  typedef logic [3:0] alu_flags_t;

endpackage

// File: rtl/result_fifo.sv
// Generic synchronous circular-buffer FIFO.
// Ports:
//   clk_i    clock, all updates on the rising edge
//   rst_i    synchronous active-high reset; clears pointers and count
//   push_i   write wdata_i (ignored when full)
//   wdata_i  write data
//   pop_i    drop the head entry (ignored when empty)
//   rdata_o  head entry, stable until popped
//   full_o   Depth entries held
//   empty_o  no entries held
module result_fifo #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    // Depth is a power of two, so pointers wrap by plain overflow.
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage behind the ripple-carry adder/subtractor.
// Derives {N,Z,C,V} for each accepted result, keeps the accumulator that
// feeds adder operand A, a status word with sticky overflow, an accepted-result
// counter, and buffers {flags,result} toward writeback via valid/ready.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              upstream handshake
//   in_sum/in_carry/in_overflow    adder outputs
//   sticky_clear                   clears sticky overflow SV
//   out_valid/out_ready            downstream handshake
//   out_result/out_flags           FIFO head
//   acc, status, op_count          last result, {SV,N,Z,C,V}, accept count
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             sticky_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [WIDTH-1:0] acc,
  output logic [4:0]       status,
  output logic [15:0]      op_count
);

  logic             push, pop;
  logic             fifo_full, fifo_empty;
  alu_flags_t       new_flags;
  logic [WIDTH+3:0] fifo_rdata;

  logic [WIDTH-1:0] acc_q, acc_d;
  alu_flags_t       flags_q, flags_d;
  logic             sv_q, sv_d;
  logic [15:0]      op_count_q, op_count_d;

  // Ready comes from registered state and rst only, never from out_ready.
  assign in_ready  = ~fifo_full & ~rst;
  assign out_valid = ~fifo_empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    new_flags         = '0;
    new_flags[FLAG_N] = in_sum[WIDTH-1];
    new_flags[FLAG_Z] = (in_sum == '0);
    new_flags[FLAG_C] = in_carry;
    new_flags[FLAG_V] = in_overflow;
  end

  result_fifo #(
    .Width (WIDTH + 4),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i ({new_flags, in_sum}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_result = fifo_rdata[WIDTH-1:0];
  assign out_flags  = fifo_rdata[WIDTH+3:WIDTH];

  always_comb begin
    acc_d      = acc_q;
    flags_d    = flags_q;
    sv_d       = sv_q;
    op_count_d = op_count_q;
    if (push) begin
      acc_d      = in_sum;
      flags_d    = new_flags;
      op_count_d = op_count_q + 16'd1;
      // A concurrent clear drops the old history but the new overflow wins.
      sv_d       = (sticky_clear ? 1'b0 : sv_q) | in_overflow;
    end else if (sticky_clear) begin
      sv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      flags_q    <= '0;
      sv_q       <= 1'b0;
      op_count_q <= '0;
    end else begin
      acc_q      <= acc_d;
      flags_q    <= flags_d;
      sv_q       <= sv_d;
      op_count_q <= op_count_d;
    end
  end

  assign acc      = acc_q;
  assign status   = {sv_q, flags_q};
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int W = 16;
  localparam int D = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_sum;
  logic          in_carry, in_overflow, sticky_clear;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic [3:0]    out_flags;
  logic [W-1:0]  acc;
  logic [4:0]    status;
  logic [15:0]   op_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .sticky_clear (sticky_clear),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .acc          (acc),
    .status       (status),
    .op_count     (op_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    logic        iv;
    logic [15:0] sum;
    logic        c;
    logic        o;
    logic        sc;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_res;
    logic [3:0]  e_fl;
    logic        e_ir;
    logic [15:0] e_acc;
    logic [4:0]  e_st;
    logic [15:0] e_opc;
  } vec_t;

  vec_t vecs[10];

  // Behavioural reference: a queue of {flags,result} plus architectural state.
  logic [19:0] mq[$];
  logic [15:0] m_acc;
  logic [3:0]  m_fl;
  logic        m_sv;
  int          m_opc;

  function automatic logic [3:0] flags_of(input logic [15:0] s, input logic c, input logic o);
    return {s[15], s == 16'h0, c, o};
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_sum = '0; in_carry = 0; in_overflow = 0;
    sticky_clear = 0; out_ready = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;

    // Reset behaviour
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_status", status, 0);
    chk("rst_op_count", op_count, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed table
    vecs[0] = '{"add_ovf",   1, 16'h8000, 0, 1, 0, 0, 1, 16'h8000, 4'b1001, 1, 16'h8000, 5'b11001, 16'd1};
    vecs[1] = '{"pop1",      0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 4'b0000, 1, 16'h8000, 5'b11001, 16'd1};
    vecs[2] = '{"zero",      1, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 4'b0100, 1, 16'h0000, 5'b10100, 16'd2};
    vecs[3] = '{"sclr_pop",  0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 4'b0000, 1, 16'h0000, 5'b00100, 16'd2};
    vecs[4] = '{"bp_push1",  1, 16'h0001, 0, 0, 0, 0, 1, 16'h0001, 4'b0000, 1, 16'h0001, 5'b00000, 16'd3};
    vecs[5] = '{"bp_push2",  1, 16'h0002, 0, 0, 0, 0, 1, 16'h0001, 4'b0000, 0, 16'h0002, 5'b00000, 16'd4};
    vecs[6] = '{"bp_push3",  1, 16'h0003, 0, 0, 0, 0, 1, 16'h0001, 4'b0000, 0, 16'h0002, 5'b00000, 16'd4};
    vecs[7] = '{"bp_pop",    0, 16'h0000, 0, 0, 0, 1, 1, 16'h0002, 4'b0000, 1, 16'h0002, 5'b00000, 16'd4};
    vecs[8] = '{"push_pop",  1, 16'h1234, 0, 0, 0, 1, 1, 16'h1234, 4'b0000, 1, 16'h1234, 5'b00000, 16'd5};
    vecs[9] = '{"fill",      1, 16'hFFFF, 1, 0, 0, 0, 1, 16'h1234, 4'b0000, 0, 16'hFFFF, 5'b01010, 16'd6};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = vecs[i].iv; in_sum = vecs[i].sum; in_carry = vecs[i].c;
      in_overflow = vecs[i].o; sticky_clear = vecs[i].sc; out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_out_valid"}, out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        chk({vecs[i].name, "_out_result"}, out_result, vecs[i].e_res);
        chk({vecs[i].name, "_out_flags"}, out_flags, vecs[i].e_fl);
      end
      chk({vecs[i].name, "_in_ready"}, in_ready, vecs[i].e_ir);
      chk({vecs[i].name, "_acc"}, acc, vecs[i].e_acc);
      chk({vecs[i].name, "_status"}, status, vecs[i].e_st);
      chk({vecs[i].name, "_op_count"}, op_count, vecs[i].e_opc);
    end

    // Mid-operation reset with FIFO full
    @(negedge clk);
    idle_inputs();
    out_ready = 1;
    rst = 1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_acc", acc, 0);
    chk("midrst_status", status, 0);
    chk("midrst_op_count", op_count, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("midrst_ready_after", in_ready, 1);
    chk("midrst_still_empty", out_valid, 0);

    // Counter wrap: push+pop every cycle keeps the FIFO at one entry
    @(negedge clk);
    in_valid = 1; in_sum = 16'h0001; out_ready = 1;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", op_count, 16'hFFFF);
    chk("wrap_sv_clear", status[4], 0);
    @(negedge clk);
    sticky_clear = 1; in_overflow = 1;
    @(posedge clk);
    #1;
    chk("wrap_zero", op_count, 16'h0000);
    chk("wrap_sclr_push_sv", status[4], 1);
    chk("wrap_v", status[0], 1);
    chk("wrap_acc", acc, 16'h0001);

    // Randomized run against the reference model
    @(negedge clk);
    idle_inputs();
    rst = 1;
    mq.delete(); m_acc = '0; m_fl = '0; m_sv = 0; m_opc = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        push_m, pop_m;
      logic [15:0] s;
      @(negedge clk);
      chk("rnd_out_valid", out_valid, (mq.size() != 0));
      if (mq.size() != 0) begin
        chk("rnd_out_result", out_result, mq[0][15:0]);
        chk("rnd_out_flags", out_flags, mq[0][19:16]);
      end
      chk("rnd_in_ready", in_ready, (!rst && mq.size() < D));
      chk("rnd_acc", acc, m_acc);
      chk("rnd_status", status, {m_sv, m_fl});
      chk("rnd_op_count", op_count, m_opc[15:0]);

      rst = ($urandom_range(0, 63) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: s = 16'h0000;
        1: s = 16'h8000;
        2: s = 16'hFFFF;
        default: s = 16'($urandom);
      endcase
      in_sum = s;
      in_carry = 1'($urandom);
      in_overflow = 1'($urandom);
      sticky_clear = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);

      if (rst) begin
        mq.delete(); m_acc = '0; m_fl = '0; m_sv = 0; m_opc = 0;
      end else begin
        push_m = in_valid && (mq.size() < D);
        pop_m  = out_ready && (mq.size() != 0);
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
          mq.push_back({flags_of(s, in_carry, in_overflow), s});
          m_acc = s;
          m_fl  = flags_of(s, in_carry, in_overflow);
          m_opc = (m_opc + 1) % 65536;
          m_sv  = (sticky_clear ? 1'b0 : m_sv) | in_overflow;
        end else if (sticky_clear) begin
          m_sv = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
